vpu2_ext_loader: RTL
====================

Name: vpu2_ext_loader

Overview:
- Double-buffered (ping-pong) operand loader directly upstream of the VPU2 MulAcc stage; drives its 12-lane i_vpu2_extdin bus.
- Accepts 12-lane operand beats from the DMA/stream side over a valid/ready handshake and fills one bank.
- Concurrently serves VPU2 reads from the other bank, keyed by VPU2's o_vpu2_rden/o_vpu2_rdaddr.
- Read data lands exactly RD_LATENCY cycles after the read request, aligned with VPU2's datapath valid.

Parameters:
- DATA_WIDTH, 39, lane width in bits.
- DATA_LENGTH, 4096, words per bank; must be a power of 2, 2..4096.
- AWIDTH, 12, address width; must equal log2(DATA_LENGTH).
- BRAM_DELAY, 1, internal bank RAM read latency in cycles.
- RD_LATENCY, 4, i_rden-to-o_extdin latency; equals VPU2 URAM_DELAY; must be >= BRAM_DELAY.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous, active-low reset.
- i_s_valid, input, 1, stream beat valid.
- o_s_ready, output, 1, stream beat ready.
- i_s_data, input, 12*DATA_WIDTH, beat; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_bank_full, output, 1, the read bank holds a complete DATA_LENGTH-word set.
- i_release, input, 1, single-cycle pulse: VPU2 pass done; frees the read bank.
- i_rden, input, 1, read request (from o_vpu2_rden).
- i_rdaddr, input, AWIDTH, read address (from o_vpu2_rdaddr).
- o_extdin, output, 12*DATA_WIDTH, operand to VPU2 i_vpu2_extdin.
- o_err, output, 1, sticky protocol error flag.

Behaviour:
- Reset values: o_s_ready=0, o_bank_full=0, o_extdin=0, o_err=0. Both banks EMPTY; wr_bank=0, rd_bank=0, fill counter=0.
- o_s_ready is registered. It rises the first cycle after reset release and is 1 whenever bank[wr_bank] is EMPTY.
- Per-bank status is 1 bit: EMPTY or FULL.
- Write path: a beat transfers when i_s_valid && o_s_ready.
  - Beat is written to bank[wr_bank] at address fill_cnt; fill_cnt increments.
  - On the transfer with fill_cnt==DATA_LENGTH-1: bank[wr_bank] becomes FULL, fill_cnt wraps to 0, wr_bank toggles.
  - o_s_ready drops the following cycle if the new bank[wr_bank] is FULL.
- Read bank: o_bank_full = (status[rd_bank]==FULL), registered.
- i_release with o_bank_full=1: status[rd_bank] becomes EMPTY and rd_bank toggles on the next edge.
- i_release with o_bank_full=0: ignored and sets o_err.
- Release and fill-complete in the same cycle on different banks: both take effect.
- Release and fill-complete on the same bank cannot occur, because a bank being filled is EMPTY.
- A freed bank that becomes wr_bank raises o_s_ready one cycle after release.
- Read path: i_rdaddr is sampled when i_rden=1 and read from bank[rd_bank].
  - o_extdin presents that word exactly RD_LATENCY cycles later.
  - Structure: BRAM_DELAY RAM latency plus (RD_LATENCY-BRAM_DELAY) register stages; the rden flag is delayed alongside.
  - In cycles where the delayed rden is 0, o_extdin is 0.
  - Reads are at full rate, one per cycle; any address order is allowed.
- i_rden=1 while o_bank_full=0: the read is still performed on bank[rd_bank] and sets o_err.
- A read and a write to the same physical bank never occur together, because banks are disjoint by status.
- rd_bank is sampled per request. A release while reads are in flight does not corrupt them: pipelined data was already fetched.
- o_err clears only on reset.
- Reset mid-fill: partial data is discarded, both banks return to EMPTY, and counters clear.
- Throughput:
  - Steady state: one bank filling while the other is read.
  - After each release, a full DATA_LENGTH-beat fill follows with no bubbles if i_s_valid stays high.

Decomposition:
- Shared package/header entries: lane count 12; DATA_LENGTH, taken from COMMON_DATA_LENGTH; BRAM/URAM delay constants; bank status encoding.
- One natural sub-module, vpu2_ext_bank: simple dual-port RAM of DATA_LENGTH x 12*DATA_WIDTH with BRAM_DELAY read latency; instantiated twice, bank select muxed in the top level.

Test Plan:
- Bank fill: reset, DATA_LENGTH=8; stream beats with lane0=beat index 0..7 -> o_s_ready stays high through beat 7, then the second bank starts filling; o_bank_full=1 two cycles after beat 7.
- Read latency: i_rden=1 with i_rdaddr=5 at cycle T -> o_extdin lane0 = 5 at T+4, and o_extdin=0 at T+3 and T+5 when those cycles have no request.
- Ping-pong: fill bank0 (values 0..7) and bank1 (100..107) -> o_s_ready=0. Pulse i_release -> reads return 100..107 and o_s_ready returns to 1 one cycle later.
- Simultaneous events: i_release on the same cycle as the final beat of the other bank -> both banks update correctly; o_bank_full stays 1 and now reflects the new bank; o_err=0.
- Errors: i_release with o_bank_full=0 -> o_err=1 and persists; a separate run with i_rden while the bank is empty -> o_err=1.
- Reset mid-operation: assert rst_n=0 after 3 of 8 beats -> all outputs return to reset values; a fresh fill of 8 beats then reads back correctly.

Source files
------------

// File: rtl/vpu2_ext_loader_pkg.sv
// Shared constants and types for the VPU2 external operand loader.
// Lane count, default depth and delays match the VPU2 datapath they feed.
package vpu2_ext_loader_pkg;

  localparam int LANES              = 12;
  localparam int COMMON_DATA_LENGTH = 4096;
  localparam int BRAM_DELAY_DEF     = 1;
  localparam int URAM_DELAY_DEF     = 4;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_status_t;

endpackage

// File: rtl/vpu2_ext_loader_bank.sv
// Simple dual-port operand bank: one write port, one read port whose data
// appears BRAM_DELAY cycles after the read request. Contents are not reset.
module vpu2_ext_bank #(
  parameter int WIDTH      = 468,
  parameter int DEPTH      = 4096,
  parameter int AWIDTH     = 12,
  parameter int BRAM_DELAY = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_pipe_reg [BRAM_DELAY];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // First stage is the RAM output register; any extra stages model deeper pipelining.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_pipe_reg[0] <= mem[rd_addr];
    end
    for (int i = 1; i < BRAM_DELAY; i++) begin
      rd_pipe_reg[i] <= rd_pipe_reg[i-1];
    end
  end

  assign rd_data = rd_pipe_reg[BRAM_DELAY-1];

endmodule

// File: rtl/vpu2_ext_loader.sv
// Ping-pong operand loader in front of the VPU2 MulAcc stage: one bank fills
// from the stream while the other is read with fixed RD_LATENCY.
module vpu2_ext_loader
  import vpu2_ext_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 39,
  parameter int DATA_LENGTH = COMMON_DATA_LENGTH,
  parameter int AWIDTH      = 12,
  parameter int BRAM_DELAY  = BRAM_DELAY_DEF,
  parameter int RD_LATENCY  = URAM_DELAY_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_s_valid,
  output logic                        o_s_ready,
  input  logic [LANES*DATA_WIDTH-1:0] i_s_data,
  output logic                        o_bank_full,
  input  logic                        i_release,
  input  logic                        i_rden,
  input  logic [AWIDTH-1:0]           i_rdaddr,
  output logic [LANES*DATA_WIDTH-1:0] o_extdin,
  output logic                        o_err
);

  localparam int BW   = LANES * DATA_WIDTH;
  localparam int POST = RD_LATENCY - BRAM_DELAY;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DATA_LENGTH - 1);

  bank_status_t      status_reg [2];
  bank_status_t      status_next [2];
  logic              wr_bank_reg, wr_bank_next;
  logic              rd_bank_reg, rd_bank_next;
  logic [AWIDTH-1:0] fill_cnt_reg, fill_cnt_next;
  logic              s_ready_reg, s_ready_next;
  logic              bank_full_reg, bank_full_next;
  logic              err_reg, err_next;
  logic              wr_fire, fill_done, release_ok;

  always_comb begin
    wr_fire        = i_s_valid && s_ready_reg;
    fill_done      = wr_fire && (fill_cnt_reg == LAST_ADDR);
    release_ok     = i_release && bank_full_reg;
    status_next    = status_reg;
    wr_bank_next   = wr_bank_reg;
    rd_bank_next   = rd_bank_reg;
    fill_cnt_next  = fill_cnt_reg;
    err_next       = err_reg;

    if (wr_fire) begin
      fill_cnt_next = fill_done ? '0 : fill_cnt_reg + AWIDTH'(1);
    end
    if (fill_done) begin
      status_next[wr_bank_reg] = BANK_FULL;
      wr_bank_next             = ~wr_bank_reg;
    end
    if (release_ok) begin
      status_next[rd_bank_reg] = BANK_EMPTY;
      rd_bank_next             = ~rd_bank_reg;
    end
    if ((i_release || i_rden) && !bank_full_reg) begin
      err_next = 1'b1;
    end

    // Ready looks ahead so no beat is ever accepted into a bank that just filled.
    s_ready_next = (status_next[wr_bank_next] == BANK_EMPTY);
    // On release, switch straight to the incoming bank's status to avoid a stale high.
    if (release_ok) begin
      bank_full_next = (status_next[rd_bank_next] == BANK_FULL);
    end else begin
      bank_full_next = (status_reg[rd_bank_reg] == BANK_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_reg[0] <= BANK_EMPTY;
      status_reg[1] <= BANK_EMPTY;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b0;
      fill_cnt_reg  <= '0;
      s_ready_reg   <= 1'b0;
      bank_full_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      status_reg    <= status_next;
      wr_bank_reg   <= wr_bank_next;
      rd_bank_reg   <= rd_bank_next;
      fill_cnt_reg  <= fill_cnt_next;
      s_ready_reg   <= s_ready_next;
      bank_full_reg <= bank_full_next;
      err_reg       <= err_next;
    end
  end

  assign o_s_ready   = s_ready_reg;
  assign o_bank_full = bank_full_reg;
  assign o_err       = err_reg;

  logic [BW-1:0] bank_rd_data [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      vpu2_ext_bank #(
        .WIDTH      (BW),
        .DEPTH      (DATA_LENGTH),
        .AWIDTH     (AWIDTH),
        .BRAM_DELAY (BRAM_DELAY)
      ) u_bank (
        .clk     (clk),
        .wr_en   (wr_fire && (wr_bank_reg == 1'(gi))),
        .wr_addr (fill_cnt_reg),
        .wr_data (i_s_data),
        .rd_en   (i_rden && (rd_bank_reg == 1'(gi))),
        .rd_addr (i_rdaddr),
        .rd_data (bank_rd_data[gi])
      );
    end
  endgenerate

  // Bank select and rden travel with the request so a release cannot redirect in-flight reads.
  logic [BRAM_DELAY-1:0] rden_pipe_reg;
  logic [BRAM_DELAY-1:0] sel_pipe_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rden_pipe_reg <= '0;
      sel_pipe_reg  <= '0;
    end else begin
      rden_pipe_reg[0] <= i_rden;
      sel_pipe_reg[0]  <= rd_bank_reg;
      for (int i = 1; i < BRAM_DELAY; i++) begin
        rden_pipe_reg[i] <= rden_pipe_reg[i-1];
        sel_pipe_reg[i]  <= sel_pipe_reg[i-1];
      end
    end
  end

  logic [BW-1:0] ram_gated;

  always_comb begin
    ram_gated = '0;
    if (rden_pipe_reg[BRAM_DELAY-1]) begin
      ram_gated = sel_pipe_reg[BRAM_DELAY-1] ? bank_rd_data[1] : bank_rd_data[0];
    end
  end

  generate
    if (POST == 0) begin : g_no_post
      assign o_extdin = ram_gated;
    end else begin : g_post
      logic [BW-1:0] data_pipe_reg [POST];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < POST; i++) begin
            data_pipe_reg[i] <= '0;
          end
        end else begin
          data_pipe_reg[0] <= ram_gated;
          for (int i = 1; i < POST; i++) begin
            data_pipe_reg[i] <= data_pipe_reg[i-1];
          end
        end
      end

      assign o_extdin = data_pipe_reg[POST-1];
    end
  endgenerate

endmodule
